wb_master_dual: RTL and testbench
=================================

# wb_master_dual

Parametrised successor to the single-width host-command Wishbone master. Accepts 32-bit host commands (ping, single read/write, incrementing and fixed-address stream read/write), executes them as classic single-beat Wishbone cycles on either the peripheral bus (`wb_*`) or the memory bus (`mem_*`), and returns responses to the output handler. It sits between the host input/output handlers and the two interconnects. It adds the following over the previous generation:

- configurable data and address width;
- real stream-write bus cycles;
- per-command bus selection;
- back-pressure through `master_ready`;
- an optional ACK timeout.

## Interface

**Parameters**

- `DATA_WIDTH`, 32: bus and host data width; multiple of 8; must be at least 28.
- `ADDR_WIDTH`, 32: bus and host address width.
- `TIMEOUT_CYCLES`, 1024: ACK wait limit in cycles. Used only with `WB_MASTER_TIMEOUT_EN`.

**Ports**

Clock, reset and host side:

- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `master_ready` out 1: block can accept an `in_ready` beat this cycle.
- `in_ready` in 1: command/data beat valid. Sampled only when `master_ready`=1.
- `in_command` in 32: `[15:0]` opcode; `[16]` bus select (0=`wb`, 1=`mem`); other bits ignored.
- `in_address` in `ADDR_WIDTH`: start address.
- `in_data` in `DATA_WIDTH`: write data, or stream count in `[27:0]`.
- `out_ready` in 1: output handler can take a response.
- `out_en` out 1: one-cycle response strobe.
- `out_status` out 32: response status.
- `out_address` out `ADDR_WIDTH`: address of the response.
- `out_data` out `DATA_WIDTH`: response data.
- `out_data_count` out 28: remaining stream beats.

Per bus, prefix `wb_` and `mem_`:

- `*_adr_o` out `ADDR_WIDTH`
- `*_dat_o` out `DATA_WIDTH`
- `*_dat_i` in `DATA_WIDTH`
- `*_stb_o` out 1
- `*_cyc_o` out 1
- `*_we_o` out 1
- `*_msk_o` out 1
- `*_sel_o` out `DATA_WIDTH/8`
- `*_ack_i` in 1
- `*_int_i` in 1: reserved; not acted on by this block.

## Operation

**State machine:** `IDLE`, `SINGLE`, `WSTREAM`, `WSTREAM_BUS`, `RSTREAM`, `RSTREAM_BUS`, `RESPOND`, `TIMEOUT`.

**Command decode.** Only in `IDLE`, on `in_ready`. The command word, address and bus select are latched.

- **PING (0):**
  - Emits status = `~in_command`, address = 0, data = `32'h1EAF` zero-extended.
- **WRITE (1), READ (2):**
  - Drive the selected bus with `stb`=`cyc`=1 and `we` = 1/0; enter `SINGLE`.
  - On ACK: drop `stb`/`cyc`/`we` and capture `dat_i` (read); go to `RESPOND`.
- **WSTREAM_C (3), WSTREAM (4):**
  - Emit an accept response; load the count from `in_data[27:0]`; enter `WSTREAM`.
  - Each subsequent `in_ready` beat launches one write cycle (`WSTREAM_BUS`).
  - After its ACK: decrement the count; increment the address only for opcode 3.
  - When the count reaches 0: final response, status `~command`, `out_data` = last data.
- **RSTREAM_C (5), RSTREAM (6):**
  - Emit an accept response; load the count.
  - In `RSTREAM`, when `out_ready`=1, launch a read cycle (`RSTREAM_BUS`).
  - On ACK: `out_en` with the read data and `out_address` = beat address; decrement the count and `out_data_count`; increment the address only for opcode 5.
  - Count reaching 0 returns to `IDLE`.
- **Count 0:** the accept response is emitted, no bus cycles run, and the block returns to `IDLE`.
- **RW_FLAGS (7), INTERRUPT (8):** status-only response.
- **Unknown opcode:** status `32'hBADC0DE0`; remain in `IDLE`.

**Responses.**

- `RESPOND` holds the response until `out_ready`=1, then pulses `out_en` for one cycle. The same rule applies to every `out_en`.

**Bus rules.**

- At most one cycle is outstanding at a time.
- The unselected bus stays idle: `stb`/`cyc`/`we` = 0.
- `sel` is all ones; `msk` = 0.
- Addresses wrap modulo 2^`ADDR_WIDTH`.

**Back-pressure.**

- `master_ready` = 1 only in `IDLE`, and in `WSTREAM` with no cycle outstanding.
- `in_ready` while `master_ready`=0 is dropped.

## Timing

**Reset values.** Reset-low at an edge forces all outputs to reset values at that edge, including mid-cycle: `stb`/`cyc` fall immediately.

- All outputs 0, except `*_sel_o` all ones and `master_ready` = 1.
- State = `IDLE`.

**Latencies.**

- `in_ready` at edge N: `stb`/`cyc` high after edge N.
- ACK sampled at edge M: `stb`/`cyc` low after edge M; `out_en` high after edge M+1 if `out_ready`, else held until `out_ready`.
- `out_en` lasts exactly one cycle per response.

**Simultaneous events.** ACK wins over timeout expiry in the same cycle.

## Configuration

- `WB_MASTER_TIMEOUT_EN` defined:
  - An ACK counter runs while `cyc`=1.
  - When it reaches `TIMEOUT_CYCLES`: drop `stb`/`cyc`, go to `TIMEOUT`, respond with status `32'hDEAD0000 | opcode` and data 0, abort any stream, return to `IDLE`.
- Undefined: the block waits indefinitely for ACK; no counter logic is present.

## Structure

- Package `wb_master_pkg`:
  - opcode constants `COMMAND_*` (0–8);
  - bus-select bit index (16);
  - `S_PING_RESP`, `S_BAD_CMD`, `S_TIMEOUT_BASE`;
  - state enum.
- Sub-module `wb_ack_timer`: load/clear/expire counter, instantiated only under `WB_MASTER_TIMEOUT_EN`.

## Test plan

- **Ping:** cmd `0x0`.
  - Expect `out_en`, status `0xFFFFFFFF`, data `0x1EAF`, no bus activity.
- **Memory-bus single write/read:**
  - Write: cmd `0x10001`, addr `0x40`, data `0xA5A5A5A5`. Expect `mem_stb`/`mem_we` high, `wb_*` idle, status `0xFFFEFFFE`.
  - Read back: cmd `0x10002`. Expect `out_data` `0xA5A5A5A5`.
- **Incrementing stream read:** RSTREAM_C count 4 at `0x100`, with `out_ready` toggled every other cycle.
  - Expect 4 data responses at `0x100`–`0x103`, `out_data_count` 3,2,1,0.
  - Expect no bus cycle launched while `out_ready`=0.
- **Fixed-address stream write:** WSTREAM count 3.
  - Expect three `wb_we` cycles all at the same address, `master_ready` low during each, final status `~0x4`.
- **Timeout and unknown opcode:**
  - With `WB_MASTER_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, READ with no ACK: `cyc` drops at cycle 16; status `0xDEAD0002`.
  - Unknown opcode `0x9`: status `0xBADC0DE0`.
- **Reset mid-cycle and ACK/timeout tie:**
  - Reset asserted while `stb` is high: `stb`/`cyc` low next edge, `master_ready`=1, then a ping succeeds.
  - ACK coincident with timeout expiry: normal response.

Source files
------------

// File: rtl/wb_master_dual_pkg.sv
// wb_master_pkg: shared constants and FSM state type for wb_master_dual.
//   - COMMAND_* host opcodes (in_command[15:0])
//   - BUS_SEL_BIT: in_command bit choosing wb (0) or mem (1)
//   - response status/data constants
//   - state_t: controller state encoding
package wb_master_pkg;

    localparam logic [15:0] COMMAND_PING      = 16'd0;
    localparam logic [15:0] COMMAND_WRITE     = 16'd1;
    localparam logic [15:0] COMMAND_READ      = 16'd2;
    localparam logic [15:0] COMMAND_WSTREAM_C = 16'd3;
    localparam logic [15:0] COMMAND_WSTREAM   = 16'd4;
    localparam logic [15:0] COMMAND_RSTREAM_C = 16'd5;
    localparam logic [15:0] COMMAND_RSTREAM   = 16'd6;
    localparam logic [15:0] COMMAND_RW_FLAGS  = 16'd7;
    localparam logic [15:0] COMMAND_INTERRUPT = 16'd8;

    localparam int BUS_SEL_BIT = 16;

    localparam logic [15:0] S_PING_RESP    = 16'h1EAF;
    localparam logic [31:0] S_BAD_CMD      = 32'hBADC0DE0;
    localparam logic [31:0] S_TIMEOUT_BASE = 32'hDEAD0000;

    typedef enum logic [2:0] {
        IDLE, SINGLE, WSTREAM, WSTREAM_BUS, RSTREAM, RSTREAM_BUS, RESPOND, TIMEOUT
    } state_t;

endpackage

// File: rtl/wb_master_dual_if.sv
// wb_master_dual_if: one classic Wishbone master-side bus.
//   master modport: drives adr_o/dat_o/stb_o/cyc_o/we_o/msk_o/sel_o,
//                   receives dat_i/ack_i/int_i.
//   slave modport:  the mirror image.
interface wb_master_dual_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   adr_o;
    logic [DATA_WIDTH-1:0]   dat_o;
    logic [DATA_WIDTH-1:0]   dat_i;
    logic                    stb_o;
    logic                    cyc_o;
    logic                    we_o;
    logic                    msk_o;
    logic [DATA_WIDTH/8-1:0] sel_o;
    logic                    ack_i;
    logic                    int_i;

    modport master (output adr_o, dat_o, stb_o, cyc_o, we_o, msk_o, sel_o,
                    input  dat_i, ack_i, int_i);
    modport slave  (input  adr_o, dat_o, stb_o, cyc_o, we_o, msk_o, sel_o,
                    output dat_i, ack_i, int_i);
endinterface

// File: rtl/wb_ack_timer.sv
// wb_ack_timer: counts cycles while a bus cycle is open and flags expiry.
//   clk, rst (sync, active-low)
//   clr     : restart count at 0 (bus idle)
//   run     : bus cycle open, count this cycle
//   expired : asserted in the LIMIT-th cycle of an open bus cycle
module wb_ack_timer #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst || clr) cnt <= '0;
        else if (run)    cnt <= cnt + W'(1);
    end

    // cnt holds the number of completed open cycles, so LIMIT-1 means
    // the current edge is the LIMIT-th one.
    assign expired = run && (cnt == W'(LIMIT - 1));
endmodule

// File: rtl/wb_master_dual.sv
// wb_master_dual: host-command Wishbone master driving a peripheral bus (wb)
// and a memory bus (mem), one single-beat cycle at a time.
//   clk, rst (sync, active-low)
//   host in : in_ready/in_command/in_address/in_data, master_ready back-pressure
//   host out: out_en strobe with out_status/out_address/out_data/out_data_count,
//             held until out_ready
//   wb, mem : Wishbone master modports
// Optional feature macro WB_MASTER_TIMEOUT_EN: abort a bus cycle with a
// timeout response after TIMEOUT_CYCLES cycles without ACK.
module wb_master_dual
    import wb_master_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  master_ready,
    input  logic                  in_ready,
    input  logic [31:0]           in_command,
    input  logic [ADDR_WIDTH-1:0] in_address,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  out_ready,
    output logic                  out_en,
    output logic [31:0]           out_status,
    output logic [ADDR_WIDTH-1:0] out_address,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [27:0]           out_data_count,
    wb_master_dual_if.master      wb,
    wb_master_dual_if.master      mem
);
    state_t                state_q, state_d, ret_q, ret_d;
    logic [31:0]           cmd_q, cmd_d;
    logic                  bsel_q, bsel_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [27:0]           cnt_q, cnt_d;
    logic                  cyc_q, cyc_d, we_q, we_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic                  oen_d;
    logic [31:0]           ostat_d;
    logic [ADDR_WIDTH-1:0] oadr_d;
    logic [DATA_WIDTH-1:0] odat_d;
    logic [27:0]           ocnt_d;
    logic                  ack, expired, stream_inc;
    logic [DATA_WIDTH-1:0] rdat;
    logic                  unused_int;

`ifdef WB_MASTER_TIMEOUT_EN
    wb_ack_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
        .clk(clk), .rst(rst), .clr(!cyc_q), .run(cyc_q), .expired(expired)
    );
`else
    assign expired = 1'b0;
`endif

    assign ack        = cyc_q && (bsel_q ? mem.ack_i : wb.ack_i);
    assign rdat       = bsel_q ? mem.dat_i : wb.dat_i;
    assign stream_inc = (cmd_q[15:0] == COMMAND_WSTREAM_C) || (cmd_q[15:0] == COMMAND_RSTREAM_C);
    assign unused_int = wb.int_i ^ mem.int_i;

    assign master_ready = (state_q == IDLE) || (state_q == WSTREAM);

    // Shared address/data; only the selected bus sees stb/cyc/we.
    assign wb.adr_o  = addr_q;
    assign wb.dat_o  = dat_q;
    assign wb.stb_o  = cyc_q && !bsel_q;
    assign wb.cyc_o  = cyc_q && !bsel_q;
    assign wb.we_o   = we_q  && !bsel_q;
    assign wb.msk_o  = 1'b0;
    assign wb.sel_o  = '1;
    assign mem.adr_o = addr_q;
    assign mem.dat_o = dat_q;
    assign mem.stb_o = cyc_q && bsel_q;
    assign mem.cyc_o = cyc_q && bsel_q;
    assign mem.we_o  = we_q  && bsel_q;
    assign mem.msk_o = 1'b0;
    assign mem.sel_o = '1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            ret_q          <= IDLE;
            cmd_q          <= '0;
            bsel_q         <= 1'b0;
            addr_q         <= '0;
            cnt_q          <= '0;
            cyc_q          <= 1'b0;
            we_q           <= 1'b0;
            dat_q          <= '0;
            out_en         <= 1'b0;
            out_status     <= '0;
            out_address    <= '0;
            out_data       <= '0;
            out_data_count <= '0;
        end else begin
            state_q        <= state_d;
            ret_q          <= ret_d;
            cmd_q          <= cmd_d;
            bsel_q         <= bsel_d;
            addr_q         <= addr_d;
            cnt_q          <= cnt_d;
            cyc_q          <= cyc_d;
            we_q           <= we_d;
            dat_q          <= dat_d;
            out_en         <= oen_d;
            out_status     <= ostat_d;
            out_address    <= oadr_d;
            out_data       <= odat_d;
            out_data_count <= ocnt_d;
        end
    end

    // Every response is staged into the out_* registers and parked in
    // RESPOND (or TIMEOUT) until out_ready; ret_q says where to go after.
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        cmd_d   = cmd_q;
        bsel_d  = bsel_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        dat_d   = dat_q;
        oen_d   = 1'b0;
        ostat_d = out_status;
        oadr_d  = out_address;
        odat_d  = out_data;
        ocnt_d  = out_data_count;

        case (state_q)
            IDLE: if (in_ready) begin
                cmd_d   = in_command;
                bsel_d  = in_command[BUS_SEL_BIT];
                addr_d  = in_address;
                cnt_d   = in_data[27:0];
                ostat_d = ~in_command;
                oadr_d  = in_address;
                odat_d  = '0;
                ocnt_d  = in_data[27:0];
                state_d = RESPOND;
                ret_d   = IDLE;
                case (in_command[15:0])
                    COMMAND_PING: begin
                        oadr_d = '0;
                        odat_d = DATA_WIDTH'(S_PING_RESP);
                        ocnt_d = '0;
                    end
                    COMMAND_WRITE, COMMAND_READ: begin
                        cyc_d   = 1'b1;
                        we_d    = (in_command[15:0] == COMMAND_WRITE);
                        dat_d   = in_data;
                        state_d = SINGLE;
                    end
                    COMMAND_WSTREAM_C, COMMAND_WSTREAM:
                        if (in_data[27:0] != 28'd0) ret_d = WSTREAM;
                    COMMAND_RSTREAM_C, COMMAND_RSTREAM:
                        if (in_data[27:0] != 28'd0) ret_d = RSTREAM;
                    COMMAND_RW_FLAGS, COMMAND_INTERRUPT: begin
                        oadr_d = '0;
                        ocnt_d = '0;
                    end
                    default: begin
                        ostat_d = S_BAD_CMD;
                        oadr_d  = '0;
                        ocnt_d  = '0;
                    end
                endcase
            end
            SINGLE: if (ack) begin
                cyc_d   = 1'b0;
                we_d    = 1'b0;
                ostat_d = ~cmd_q;
                oadr_d  = addr_q;
                odat_d  = we_q ? dat_q : rdat;
                ocnt_d  = '0;
                state_d = RESPOND;
                ret_d   = IDLE;
            end
            WSTREAM: if (in_ready) begin
                cyc_d   = 1'b1;
                we_d    = 1'b1;
                dat_d   = in_data;
                state_d = WSTREAM_BUS;
            end
            WSTREAM_BUS: if (ack) begin
                cyc_d = 1'b0;
                we_d  = 1'b0;
                cnt_d = cnt_q - 28'd1;
                if (stream_inc) addr_d = addr_q + ADDR_WIDTH'(1);
                if (cnt_q == 28'd1) begin
                    ostat_d = ~cmd_q;
                    oadr_d  = addr_q;
                    odat_d  = dat_q;
                    ocnt_d  = '0;
                    state_d = RESPOND;
                    ret_d   = IDLE;
                end else begin
                    state_d = WSTREAM;
                end
            end
            RSTREAM: if (out_ready) begin
                cyc_d   = 1'b1;
                we_d    = 1'b0;
                state_d = RSTREAM_BUS;
            end
            RSTREAM_BUS: if (ack) begin
                cyc_d   = 1'b0;
                cnt_d   = cnt_q - 28'd1;
                if (stream_inc) addr_d = addr_q + ADDR_WIDTH'(1);
                ostat_d = ~cmd_q;
                oadr_d  = addr_q;
                odat_d  = rdat;
                ocnt_d  = cnt_q - 28'd1;
                state_d = RESPOND;
                ret_d   = (cnt_q == 28'd1) ? IDLE : RSTREAM;
            end
            RESPOND, TIMEOUT: if (out_ready) begin
                oen_d   = 1'b1;
                state_d = ret_q;
            end
        endcase

        // ACK has priority: expiry only matters when no ACK arrived.
        if (cyc_q && !ack && expired) begin
            cyc_d   = 1'b0;
            we_d    = 1'b0;
            ostat_d = S_TIMEOUT_BASE | {16'h0, cmd_q[15:0]};
            oadr_d  = addr_q;
            odat_d  = '0;
            ocnt_d  = '0;
            state_d = TIMEOUT;
            ret_d   = IDLE;
        end
    end
endmodule

// File: tb/tb_wb_master_dual.sv
module tb_wb_master_dual;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_ready = 1'b0;
    logic [31:0] in_command = '0, in_address = '0, in_data = '0;
    logic        out_ready = 1'b0;
    logic        master_ready, out_en;
    logic [31:0] out_status, out_address, out_data;
    logic [27:0] out_data_count;
    logic [31:0] wb_store  [256];
    logic [31:0] mem_store [256];
    int checks = 0;
    int failures = 0;

    wb_master_dual_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) wbb ();
    wb_master_dual_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) memb ();

    wb_master_dual #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .master_ready(master_ready), .in_ready(in_ready),
        .in_command(in_command), .in_address(in_address), .in_data(in_data),
        .out_ready(out_ready), .out_en(out_en), .out_status(out_status),
        .out_address(out_address), .out_data(out_data), .out_data_count(out_data_count),
        .wb(wbb), .mem(memb)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic send_cmd(input logic [31:0] c, input logic [31:0] a, input logic [31:0] d);
        in_ready = 1'b1; in_command = c; in_address = a; in_data = d;
        tick;
        in_ready = 1'b0;
    endtask

    // Acknowledge the open cycle on one bus, acting as a small memory.
    task automatic ack_beat(input bit m);
        if (m) begin
            if (memb.we_o) mem_store[memb.adr_o[7:0]] = memb.dat_o;
            memb.dat_i = mem_store[memb.adr_o[7:0]];
            memb.ack_i = 1'b1;
        end else begin
            if (wbb.we_o) wb_store[wbb.adr_o[7:0]] = wbb.dat_o;
            wbb.dat_i = wb_store[wbb.adr_o[7:0]];
            wbb.ack_i = 1'b1;
        end
        tick;
        memb.ack_i = 1'b0;
        wbb.ack_i  = 1'b0;
    endtask

    task automatic wait_out(input int maxc, output bit ok, output bit saw_bus);
        int n = 0;
        ok = 1'b0; saw_bus = 1'b0;
        while (n < maxc && !ok) begin
            if (wbb.cyc_o || memb.cyc_o) saw_bus = 1'b1;
            if (out_en) ok = 1'b1;
            else begin tick; n++; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; tick; tick;
        checks++; if (master_ready !== 1'b1) begin failures++; $display("FAIL reset_master_ready got=%h exp=1", master_ready); end
        checks++; if (out_en !== 1'b0) begin failures++; $display("FAIL reset_out_en got=%h exp=0", out_en); end
        checks++; if ({wbb.stb_o, wbb.cyc_o, memb.stb_o, memb.cyc_o} !== 4'b0) begin failures++; $display("FAIL reset_stb_cyc got=%b exp=0000", {wbb.stb_o, wbb.cyc_o, memb.stb_o, memb.cyc_o}); end
        checks++; if (wbb.sel_o !== 4'hF || memb.sel_o !== 4'hF) begin failures++; $display("FAIL reset_sel got=%h/%h exp=f/f", wbb.sel_o, memb.sel_o); end
        checks++; if (out_status !== 32'h0 || out_data !== 32'h0) begin failures++; $display("FAIL reset_out got=%h/%h exp=0/0", out_status, out_data); end
        rst = 1'b1; tick;
    endtask

    task automatic test_ping;
        bit ok, sb;
        out_ready = 1'b1;
        send_cmd(32'h0, 32'h55, 32'h77);
        wait_out(20, ok, sb);
        checks++; if (!ok) begin failures++; $display("FAIL ping_out_en got=timeout exp=pulse"); end
        checks++; if (out_status !== 32'hFFFFFFFF) begin failures++; $display("FAIL ping_status got=%h exp=ffffffff", out_status); end
        checks++; if (out_data !== 32'h1EAF || out_address !== 32'h0) begin failures++; $display("FAIL ping_data got=%h@%h exp=1eaf@0", out_data, out_address); end
        checks++; if (sb !== 1'b0) begin failures++; $display("FAIL ping_bus_idle got=%b exp=0", sb); end
        tick;
        checks++; if (out_en !== 1'b0) begin failures++; $display("FAIL ping_one_pulse got=%h exp=0", out_en); end
    endtask

    task automatic test_mem_single;
        bit ok, sb;
        out_ready = 1'b1;
        send_cmd(32'h10001, 32'h40, 32'hA5A5A5A5);
        checks++; if ({memb.stb_o, memb.cyc_o, memb.we_o} !== 3'b111) begin failures++; $display("FAIL wr_mem_strobes got=%b exp=111", {memb.stb_o, memb.cyc_o, memb.we_o}); end
        checks++; if ({wbb.stb_o, wbb.cyc_o, wbb.we_o} !== 3'b000) begin failures++; $display("FAIL wr_wb_idle got=%b exp=000", {wbb.stb_o, wbb.cyc_o, wbb.we_o}); end
        checks++; if (memb.adr_o !== 32'h40 || memb.dat_o !== 32'hA5A5A5A5) begin failures++; $display("FAIL wr_adr_dat got=%h/%h exp=40/a5a5a5a5", memb.adr_o, memb.dat_o); end
        checks++; if (master_ready !== 1'b0) begin failures++; $display("FAIL wr_master_ready got=%h exp=0", master_ready); end
        ack_beat(1'b1);
        checks++; if (memb.cyc_o !== 1'b0 || memb.stb_o !== 1'b0) begin failures++; $display("FAIL wr_cyc_drop got=%b exp=0", memb.cyc_o); end
        tick;
        checks++; if (out_en !== 1'b1 || out_status !== 32'hFFFEFFFE) begin failures++; $display("FAIL wr_resp got=%h/%h exp=1/fffefffe", out_en, out_status); end
        send_cmd(32'h10002, 32'h40, 32'h0);
        checks++; if ({memb.stb_o, memb.we_o} !== 2'b10) begin failures++; $display("FAIL rd_mem_strobes got=%b exp=10", {memb.stb_o, memb.we_o}); end
        ack_beat(1'b1);
        wait_out(20, ok, sb);
        checks++; if (!ok || out_data !== 32'hA5A5A5A5) begin failures++; $display("FAIL rd_data got=%h ok=%b exp=a5a5a5a5", out_data, ok); end
        tick;
    endtask

    task automatic test_rstream_inc;
        bit ok, sb, prev_stb;
        int n, bad, extra;
        logic [31:0] ga [4];
        logic [31:0] gd [4];
        logic [27:0] gc [4];
        for (int i = 0; i < 4; i++) wb_store[i] = 32'hD0000100 + i;
        out_ready = 1'b1;
        send_cmd(32'h5, 32'h100, 32'd4);
        wait_out(20, ok, sb);
        checks++; if (!ok || out_status !== 32'hFFFFFFFA) begin failures++; $display("FAIL rs_accept got=%h ok=%b exp=fffffffa", out_status, ok); end
        n = 0; bad = 0; prev_stb = 1'b0;
        for (int c = 0; c < 200 && n < 4; c++) begin
            if (wbb.stb_o && !prev_stb && !out_ready) bad++;
            prev_stb = wbb.stb_o;
            if (out_en && c > 0) begin ga[n] = out_address; gd[n] = out_data; gc[n] = out_data_count; n++; end
            if (wbb.stb_o && !wbb.ack_i) begin wbb.ack_i = 1'b1; wbb.dat_i = wb_store[wbb.adr_o[7:0]]; end
            else wbb.ack_i = 1'b0;
            out_ready = ~out_ready;
            tick;
        end
        wbb.ack_i = 1'b0;
        checks++; if (n !== 4) begin failures++; $display("FAIL rs_beats got=%0d exp=4", n); end
        for (int i = 0; i < n; i++) begin
            checks++; if (ga[i] !== 32'h100 + i) begin failures++; $display("FAIL rs_addr%0d got=%h exp=%h", i, ga[i], 32'h100 + i); end
            checks++; if (gd[i] !== 32'hD0000100 + i) begin failures++; $display("FAIL rs_data%0d got=%h exp=%h", i, gd[i], 32'hD0000100 + i); end
            checks++; if (gc[i] !== 28'(3 - i)) begin failures++; $display("FAIL rs_count%0d got=%0d exp=%0d", i, gc[i], 3 - i); end
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL rs_launch_stalled got=%0d exp=0", bad); end
        out_ready = 1'b1; extra = 0;
        repeat (6) begin if (out_en || wbb.cyc_o) extra++; tick; end
        checks++; if (extra !== 0 || master_ready !== 1'b1) begin failures++; $display("FAIL rs_done got=%0d/%b exp=0/1", extra, master_ready); end
    endtask

    task automatic test_wstream_fixed;
        bit ok, sb;
        out_ready = 1'b1;
        send_cmd(32'h4, 32'h200, 32'd3);
        wait_out(20, ok, sb);
        checks++; if (!ok || out_status !== 32'hFFFFFFFB) begin failures++; $display("FAIL ws_accept got=%h ok=%b exp=fffffffb", out_status, ok); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (master_ready !== 1'b1) begin failures++; $display("FAIL ws_ready_before%0d got=%h exp=1", i, master_ready); end
            send_cmd(32'hFFFF, 32'h0, 32'hC0 + i);
            checks++; if ({wbb.stb_o, wbb.we_o} !== 2'b11 || wbb.adr_o !== 32'h200 || wbb.dat_o !== 32'hC0 + i) begin
                failures++; $display("FAIL ws_beat%0d got=%b@%h=%h exp=11@200=%h", i, {wbb.stb_o, wbb.we_o}, wbb.adr_o, wbb.dat_o, 32'hC0 + i); end
            checks++; if (master_ready !== 1'b0) begin failures++; $display("FAIL ws_busy%0d got=%h exp=0", i, master_ready); end
            // An input beat offered while busy must be dropped.
            if (i == 0) begin in_ready = 1'b1; in_data = 32'hEE; end
            ack_beat(1'b0);
            in_ready = 1'b0;
            checks++; if (wbb.stb_o !== 1'b0) begin failures++; $display("FAIL ws_drop%0d got=%h exp=0", i, wbb.stb_o); end
        end
        wait_out(20, ok, sb);
        checks++; if (!ok || out_status !== 32'hFFFFFFFB || out_data !== 32'hC2) begin failures++; $display("FAIL ws_final got=%h/%h ok=%b exp=fffffffb/c2", out_status, out_data, ok); end
        tick;
    endtask

    task automatic test_bad_opcode;
        bit ok, sb;
        out_ready = 1'b1;
        send_cmd(32'h9, 32'h0, 32'h0);
        wait_out(20, ok, sb);
        checks++; if (!ok || out_status !== 32'hBADC0DE0) begin failures++; $display("FAIL bad_status got=%h ok=%b exp=badc0de0", out_status, ok); end
        tick;
        checks++; if (master_ready !== 1'b1 || sb !== 1'b0) begin failures++; $display("FAIL bad_idle got=%b/%b exp=1/0", master_ready, sb); end
    endtask

`ifdef WB_MASTER_TIMEOUT_EN
    task automatic test_timeout;
        bit ok, sb;
        int n = 0;
        out_ready = 1'b1;
        send_cmd(32'h2, 32'h300, 32'h0);
        while (wbb.cyc_o && n < 100) begin n++; tick; end
        checks++; if (n !== 16) begin failures++; $display("FAIL to_cyc_len got=%0d exp=16", n); end
        wait_out(20, ok, sb);
        checks++; if (!ok || out_status !== 32'hDEAD0002 || out_data !== 32'h0) begin failures++; $display("FAIL to_resp got=%h/%h ok=%b exp=dead0002/0", out_status, out_data, ok); end
        tick;
    endtask
`endif

    // Hold ACK back for 'hold' cycles, then complete a read normally.
    task automatic test_late_ack(input int hold);
        bit ok, sb;
        wb_store[8'h10] = 32'h12345678;
        out_ready = 1'b1;
        send_cmd(32'h2, 32'h310, 32'h0);
        repeat (hold) tick;
        checks++; if (wbb.cyc_o !== 1'b1) begin failures++; $display("FAIL late_cyc_open got=%h exp=1", wbb.cyc_o); end
        ack_beat(1'b0);
        wait_out(20, ok, sb);
        checks++; if (!ok || out_status !== 32'hFFFFFFFD || out_data !== 32'h12345678) begin failures++; $display("FAIL late_resp got=%h/%h ok=%b exp=fffffffd/12345678", out_status, out_data, ok); end
        tick;
    endtask

    task automatic test_reset_mid;
        bit ok, sb;
        send_cmd(32'h10001, 32'h10, 32'h5);
        checks++; if (memb.stb_o !== 1'b1) begin failures++; $display("FAIL rm_stb_up got=%h exp=1", memb.stb_o); end
        rst = 1'b0; tick;
        checks++; if (memb.stb_o !== 1'b0 || memb.cyc_o !== 1'b0) begin failures++; $display("FAIL rm_stb_drop got=%b%b exp=00", memb.stb_o, memb.cyc_o); end
        checks++; if (master_ready !== 1'b1) begin failures++; $display("FAIL rm_ready got=%h exp=1", master_ready); end
        rst = 1'b1; tick;
        out_ready = 1'b1;
        send_cmd(32'h0, 32'h0, 32'h0);
        wait_out(20, ok, sb);
        checks++; if (!ok || out_status !== 32'hFFFFFFFF) begin failures++; $display("FAIL rm_ping got=%h ok=%b exp=ffffffff", out_status, ok); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        wbb.ack_i = 1'b0; wbb.dat_i = '0; wbb.int_i = 1'b0;
        memb.ack_i = 1'b0; memb.dat_i = '0; memb.int_i = 1'b0;
        for (int i = 0; i < 256; i++) begin wb_store[i] = '0; mem_store[i] = '0; end
        #1;
        test_reset;
        test_ping;
        test_mem_single;
        test_rstream_inc;
        test_wstream_fixed;
        test_bad_opcode;
`ifdef WB_MASTER_TIMEOUT_EN
        test_timeout;
        test_late_ack(15);
`else
        test_late_ack(40);
`endif
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
